// File: rtl/prbs_tx.sv
// prbs_tx: NCO-timed PRBS7 NRZ transmitter with one-tap post-cursor ISI, saturated to signed 8 bits.
// Optional build macro TX_ERR_INJECT_EN inverts every ERR_PERIOD-th transmitted bit and flags it on err_flag.
module prbs_tx #(
  parameter int unsigned PHASE_BITS = 32,
  parameter logic [6:0]  LFSR_SEED  = 7'h7F,
  parameter int unsigned ERR_PERIOD = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PHASE_BITS-1:0] fcw,
  input  logic [6:0]            amp,
  input  logic [7:0]            h1,
  input  logic                  seed_load,
  input  logic [6:0]            seed,
  output logic                  sym_tick,
  output logic [7:0]            y_n,
  output logic                  d_tx,
  output logic [15:0]           sym_cnt,
  output logic                  err_flag
);

  localparam int unsigned LFSR_W = 7;
  localparam int unsigned SAMP_W = 8;
  localparam int unsigned ACC_W  = 10;
  localparam int unsigned CNT_W  = 16;
  localparam logic [LFSR_W-1:0]      LOCKUP_SEED = 7'h7F;
  localparam logic signed [ACC_W-1:0] SAT_HI     = 10'sd127;
  localparam logic signed [ACC_W-1:0] SAT_LO     = -10'sd128;

  if (ERR_PERIOD < 2 || LFSR_SEED == '0) begin : g_bad_param
    $error("prbs_tx: ERR_PERIOD must be >= 2 and LFSR_SEED must be nonzero");
  end

  logic [PHASE_BITS-1:0]   phase;
  logic [PHASE_BITS-1:0]   phase_nxt;
  logic                    tick;
  logic [LFSR_W-1:0]       q;
  logic                    bit_new;
  logic                    inj;
  logic                    tx_bit;
  logic signed [ACC_W-1:0] amp_ext;
  logic signed [ACC_W-1:0] h1_ext;
  logic signed [ACC_W-1:0] main_term;
  logic signed [ACC_W-1:0] post_term;
  logic signed [ACC_W-1:0] y_sum;
  logic [SAMP_W-1:0]       y_sat;

  // A symbol boundary is an unsigned wrap of the phase accumulator.
  assign phase_nxt = phase + fcw;
  assign tick      = en & (phase_nxt < phase);

  assign bit_new = q[6] ^ q[5];
  assign tx_bit  = bit_new ^ inj;

  // Current d_tx is the previous symbol by the time the new sample is formed.
  assign amp_ext   = signed'(ACC_W'(amp));
  assign h1_ext    = {{(ACC_W-SAMP_W){h1[SAMP_W-1]}}, h1};
  assign main_term = tx_bit ? amp_ext : -amp_ext;
  assign post_term = d_tx ? h1_ext : -h1_ext;
  assign y_sum     = main_term + post_term;

  always_comb begin
    y_sat = y_sum[SAMP_W-1:0];
    if (y_sum > SAT_HI) begin
      y_sat = 8'h7F;
    end else if (y_sum < SAT_LO) begin
      y_sat = 8'h80;
    end
  end

`ifdef TX_ERR_INJECT_EN
  localparam int unsigned INJ_W = $clog2(ERR_PERIOD);

  logic [INJ_W-1:0] inj_cnt;

  // Ticks swallowed by a seed load are not symbols, so they neither count nor inject.
  assign inj = (inj_cnt == INJ_W'(ERR_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_cnt <= '0;
    end else if (tick && !seed_load) begin
      inj_cnt <= inj ? '0 : inj_cnt + INJ_W'(1);
    end
  end
`else
  assign inj = 1'b0;
`endif

  // Seed load wins over a coincident tick: the LFSR reloads and the symbol outputs hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= '0;
      q        <= LFSR_SEED;
      d_tx     <= 1'b0;
      y_n      <= '0;
      sym_tick <= 1'b0;
      sym_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      sym_tick <= tick;
      err_flag <= tick & inj & ~seed_load;
      if (en) begin
        phase <= phase_nxt;
      end
      if (tick) begin
        sym_cnt <= sym_cnt + CNT_W'(1);
      end
      if (seed_load) begin
        q <= (seed == '0) ? LOCKUP_SEED : seed;
      end else if (tick) begin
        q    <= {q[LFSR_W-2:0], bit_new};
        d_tx <= tx_bit;
        y_n  <= y_sat;
      end
    end
  end

endmodule

// File: tb/tb_prbs_tx.sv
// tb_prbs_tx: scoreboard bench for prbs_tx; a reference model pushes one expected symbol per wrap,
// and each scenario task pops and compares as sym_tick arrives.
module tb_prbs_tx;

  localparam int unsigned EP = 10;
`ifdef TX_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        seed_load;
  logic [31:0] fcw;
  logic [6:0]  amp;
  logic [6:0]  seed;
  logic [7:0]  h1;
  logic        sym_tick;
  logic [7:0]  y_n;
  logic        d_tx;
  logic [15:0] sym_cnt;
  logic        err_flag;

  int checks = 0;
  int errors = 0;

  prbs_tx #(.PHASE_BITS(32), .LFSR_SEED(7'h7F), .ERR_PERIOD(EP)) dut (
    .clk(clk), .rst(rst), .en(en), .fcw(fcw), .amp(amp), .h1(h1),
    .seed_load(seed_load), .seed(seed), .sym_tick(sym_tick), .y_n(y_n),
    .d_tx(d_tx), .sym_cnt(sym_cnt), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        d;
    logic        ref_d;
    logic [7:0]  y;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic et;

  logic [31:0] m_phase;
  logic [6:0]  m_q;
  logic        m_d;
  logic [7:0]  m_y;
  logic [15:0] m_cnt;
  int          m_inj_cnt;
  int          m_edge = 0;

  // Reference model: carry-out of a 33-bit add marks the wrap; sample built in integer arithmetic.
  always @(posedge clk) begin : model
    logic [32:0] sum;
    logic tk, b, inj_m;
    int yi;
    exp_t x;
    m_edge++;
    if (rst) begin
      m_phase = '0; m_q = 7'h7F; m_d = 1'b0; m_y = '0; m_cnt = '0; m_inj_cnt = 0;
      exp_q.delete();
    end else begin
      sum = {1'b0, m_phase} + {1'b0, fcw};
      tk = en && sum[32];
      if (en) m_phase = sum[31:0];
      inj_m = 1'b0;
      b = m_d;
      if (tk) m_cnt++;
      if (seed_load) begin
        m_q = (seed == 7'd0) ? 7'h7F : seed;
      end else if (tk) begin
        b = m_q[6] ^ m_q[5];
        m_q = {m_q[5:0], b};
        m_inj_cnt++;
        inj_m = INJ && (m_inj_cnt % EP == 0);
        yi = ((b ^ inj_m) ? int'(amp) : -int'(amp)) + (m_d ? int'($signed(h1)) : -int'($signed(h1)));
        if (yi > 127) yi = 127;
        else if (yi < -128) yi = -128;
        m_d = b ^ inj_m;
        m_y = 8'(yi);
      end
      if (tk) begin
        x.cyc = m_edge; x.d = m_d; x.ref_d = b; x.y = m_y; x.cnt = m_cnt; x.err = inj_m;
        exp_q.push_back(x);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; seed_load = 1'b1; seed = 7'h2A;
    fcw = 32'h8000_0000; amp = 7'd64; h1 = 8'd16;
    repeat (3) @(negedge clk);
    checks++;
    if ({sym_tick, d_tx, y_n, sym_cnt, err_flag} !== 27'd0) begin
      errors++;
      $display("FAIL reset_init: tick=%b d=%b y=%0d cnt=%0d err=%b, want all zero",
               sym_tick, d_tx, $signed(y_n), sym_cnt, err_flag);
    end
    seed_load = 1'b0; rst = 1'b0; fcw = 32'h4000_0000;
    repeat (10) @(negedge clk);
    checks++;
    if (sym_cnt !== 16'd2) begin
      errors++;
      $display("FAIL reset_run: sym_cnt=%0d want 2", sym_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sym_tick, d_tx, y_n, sym_cnt, err_flag} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid_ui: tick=%b d=%b y=%0d cnt=%0d err=%b, want all zero",
               sym_tick, d_tx, $signed(y_n), sym_cnt, err_flag);
    end
    rst = 1'b0;
  endtask

  task automatic test_prbs();
    logic ref_bits[$];
    int n = 0;
    fcw = 32'h8000_0000; amp = 7'd64; h1 = 8'd0; en = 1'b1;
    for (int i = 0; i < 520; i++) begin
      @(negedge clk);
      et = (exp_q.size() > 0) && (exp_q[0].cyc == m_edge);
      checks++;
      if (sym_tick !== et) begin
        errors++;
        $display("FAIL prbs_tick edge=%0d: sym_tick=%b want %b", m_edge, sym_tick, et);
      end
      if (et) begin
        e = exp_q.pop_front();
        checks++;
        if ({d_tx, y_n, sym_cnt, err_flag} !== {e.d, e.y, e.cnt, e.err}) begin
          errors++;
          $display("FAIL prbs_sb edge=%0d: d=%b y=%0d cnt=%0d err=%b want d=%b y=%0d cnt=%0d err=%b",
                   m_edge, d_tx, $signed(y_n), sym_cnt, err_flag, e.d, $signed(e.y), e.cnt, e.err);
        end
        checks++;
        if (y_n !== (e.d ? 8'h40 : 8'hC0)) begin
          errors++;
          $display("FAIL prbs_nrz n=%0d: y=%0d want %0d", n, $signed(y_n), e.d ? 64 : -64);
        end
        if (n >= 127) begin
          checks++;
          if ((d_tx ^ e.err) !== ref_bits[n-127]) begin
            errors++;
            $display("FAIL prbs_period n=%0d: bit=%b want %b", n, d_tx ^ e.err, ref_bits[n-127]);
          end
        end
        if (n == 126) begin
          checks++;
          if (sym_cnt !== 16'd127) begin
            errors++;
            $display("FAIL prbs_cnt127: sym_cnt=%0d want 127", sym_cnt);
          end
        end
        ref_bits.push_back(e.ref_d);
        n++;
      end
    end
    checks++;
    if (n != 260) begin
      errors++;
      $display("FAIL prbs_rate: %0d ticks in 520 cycles, want 260", n);
    end
  endtask

  task automatic test_isi();
    int tbl[3][4];
    logic [6:0] amps[3];
    logic [7:0] h1s[3];
    logic prev;
    bit have_prev;
    logic [3:0] seen;
    int want;
    tbl[0] = '{-80, -48, 48, 80};
    tbl[1] = '{-128, 0, 0, 127};
    tbl[2] = '{1, -128, 127, -1};
    amps = '{7'd64, 7'd127, 7'd127};
    h1s  = '{8'd16, 8'd127, 8'h80};
    have_prev = 1'b0; prev = 1'b0;
    en = 1'b1; fcw = 32'h8000_0000;
    for (int p = 0; p < 3; p++) begin
      amp = amps[p]; h1 = h1s[p]; seen = '0;
      for (int i = 0; i < 240; i++) begin
        @(negedge clk);
        et = (exp_q.size() > 0) && (exp_q[0].cyc == m_edge);
        checks++;
        if (sym_tick !== et) begin
          errors++;
          $display("FAIL isi_tick edge=%0d: sym_tick=%b want %b", m_edge, sym_tick, et);
        end
        if (et) begin
          e = exp_q.pop_front();
          checks++;
          if ({d_tx, y_n, sym_cnt, err_flag} !== {e.d, e.y, e.cnt, e.err}) begin
            errors++;
            $display("FAIL isi_sb edge=%0d: d=%b y=%0d cnt=%0d err=%b want d=%b y=%0d cnt=%0d err=%b",
                     m_edge, d_tx, $signed(y_n), sym_cnt, err_flag, e.d, $signed(e.y), e.cnt, e.err);
          end
          if (have_prev) begin
            want = tbl[p][{e.d, prev}];
            seen[{e.d, prev}] = 1'b1;
            checks++;
            if (int'($signed(y_n)) != want) begin
              errors++;
              $display("FAIL isi_table set=%0d d=%b prev=%b: y=%0d want %0d", p, e.d, prev, $signed(y_n), want);
            end
          end
          prev = e.d;
          have_prev = 1'b1;
        end
      end
      checks++;
      if (seen !== 4'hF) begin
        errors++;
        $display("FAIL isi_cover set=%0d: combos seen %b want 1111", p, seen);
      end
    end
  endtask

  task automatic test_en_hold();
    logic hd;
    logic [7:0] hy;
    logic [15:0] hc;
    fcw = 32'h4000_0000; amp = 7'd64; h1 = 8'd0;
    for (int i = 0; i < 60; i++) begin
      en = !(i >= 10 && i < 15);
      @(negedge clk);
      et = (exp_q.size() > 0) && (exp_q[0].cyc == m_edge);
      checks++;
      if (sym_tick !== et) begin
        errors++;
        $display("FAIL en_tick edge=%0d: sym_tick=%b want %b", m_edge, sym_tick, et);
      end
      if (et) begin
        e = exp_q.pop_front();
        checks++;
        if ({d_tx, y_n, sym_cnt, err_flag} !== {e.d, e.y, e.cnt, e.err}) begin
          errors++;
          $display("FAIL en_sb edge=%0d: d=%b y=%0d cnt=%0d err=%b want d=%b y=%0d cnt=%0d err=%b",
                   m_edge, d_tx, $signed(y_n), sym_cnt, err_flag, e.d, $signed(e.y), e.cnt, e.err);
        end
      end
      if (i == 9) begin
        hd = m_d; hy = m_y; hc = m_cnt;
      end
      if (i >= 10 && i < 15) begin
        checks++;
        if ({sym_tick, d_tx, y_n, sym_cnt} !== {1'b0, hd, hy, hc}) begin
          errors++;
          $display("FAIL en_hold i=%0d: tick=%b d=%b y=%0d cnt=%0d want tick=0 d=%b y=%0d cnt=%0d",
                   i, sym_tick, d_tx, $signed(y_n), sym_cnt, hd, $signed(hy), hc);
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_seed_load();
    logic [6:0] s;
    logic [6:0] seq7f;
    logic [32:0] nx;
    logic pred;
    logic hd;
    logic [7:0] hy;
    logic [15:0] hc;
    int stage = 0;
    int nb = 0;
    s = 7'h25;
    seq7f = 7'b1000000;
    for (int i = 0; i < 100; i++) begin
      nx = {1'b0, m_phase} + {1'b0, fcw};
      pred = en && nx[32];
      seed_load = 1'b0;
      if (stage == 0 && i >= 2 && !pred) begin
        seed_load = 1'b1; seed = 7'd0; stage = 1;
      end else if (stage == 2 && pred) begin
        seed_load = 1'b1; seed = s; hd = m_d; hy = m_y; hc = m_cnt; stage = 3;
      end
      @(negedge clk);
      et = (exp_q.size() > 0) && (exp_q[0].cyc == m_edge);
      checks++;
      if (sym_tick !== et) begin
        errors++;
        $display("FAIL seed_tick edge=%0d: sym_tick=%b want %b", m_edge, sym_tick, et);
      end
      if (et) begin
        e = exp_q.pop_front();
        checks++;
        if ({d_tx, y_n, sym_cnt, err_flag} !== {e.d, e.y, e.cnt, e.err}) begin
          errors++;
          $display("FAIL seed_sb edge=%0d: d=%b y=%0d cnt=%0d err=%b want d=%b y=%0d cnt=%0d err=%b",
                   m_edge, d_tx, $signed(y_n), sym_cnt, err_flag, e.d, $signed(e.y), e.cnt, e.err);
        end
        case (stage)
          1: begin
            checks++;
            if ((d_tx ^ e.err) !== seq7f[nb]) begin
              errors++;
              $display("FAIL seed_zero bit %0d: got %b want %b", nb, d_tx ^ e.err, seq7f[nb]);
            end
            nb++;
            if (nb == 7) stage = 2;
          end
          3: begin
            checks++;
            if ({d_tx, y_n, sym_cnt, err_flag} !== {hd, hy, hc + 16'd1, 1'b0}) begin
              errors++;
              $display("FAIL seed_on_tick: d=%b y=%0d cnt=%0d err=%b want d=%b y=%0d cnt=%0d err=0",
                       d_tx, $signed(y_n), sym_cnt, err_flag, hd, $signed(hy), hc + 16'd1);
            end
            stage = 4;
          end
          4: begin
            checks++;
            if ((d_tx ^ e.err) !== (s[6] ^ s[5])) begin
              errors++;
              $display("FAIL seed_first_bit: got %b want %b", d_tx ^ e.err, s[6] ^ s[5]);
            end
            stage = 5;
          end
          default: ;
        endcase
      end
    end
    seed_load = 1'b0;
    checks++;
    if (stage != 5) begin
      errors++;
      $display("FAIL seed_sequence: reached stage %0d want 5", stage);
    end
  endtask

  task automatic test_err_inject();
    int n = 0;
    int mis = 0;
    logic want;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; fcw = 32'h8000_0000; amp = 7'd64; h1 = 8'd0; en = 1'b1; seed_load = 1'b0;
    for (int i = 0; i < 2010; i++) begin
      @(negedge clk);
      et = (exp_q.size() > 0) && (exp_q[0].cyc == m_edge);
      checks++;
      if (sym_tick !== et) begin
        errors++;
        $display("FAIL inj_tick edge=%0d: sym_tick=%b want %b", m_edge, sym_tick, et);
      end
      if (et) begin
        e = exp_q.pop_front();
        n++;
        want = INJ && (n % EP == 0);
        checks++;
        if ({d_tx, y_n, sym_cnt, err_flag} !== {e.d, e.y, e.cnt, e.err}) begin
          errors++;
          $display("FAIL inj_sb edge=%0d: d=%b y=%0d cnt=%0d err=%b want d=%b y=%0d cnt=%0d err=%b",
                   m_edge, d_tx, $signed(y_n), sym_cnt, err_flag, e.d, $signed(e.y), e.cnt, e.err);
        end
        checks++;
        if (err_flag !== want || (d_tx !== e.ref_d) !== want) begin
          errors++;
          $display("FAIL inj_symbol n=%0d: err=%b d=%b prbs=%b want err=%b inverted=%b",
                   n, err_flag, d_tx, e.ref_d, want, want);
        end
        if (d_tx !== e.ref_d) mis++;
      end
    end
    checks++;
    if (mis != (INJ ? n / EP : 0)) begin
      errors++;
      $display("FAIL inj_total: %0d inverted of %0d symbols want %0d", mis, n, INJ ? n / EP : 0);
    end
  endtask

  initial begin
    test_reset();
    test_prbs();
    test_isi();
    test_en_hold();
    test_seed_load();
    test_err_inject();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected symbols never emitted", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
